// File: rtl/uart_mmio_bridge_if.sv
// Signal bundle between the UART byte streams, the MMIO bus and the bridge.
// The master modport is the bridge side; the slave modport is the UART/responder side.
interface uart_mmio_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_rdata,
    output rx_ready, tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_rdata,
    input  rx_ready, tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, busy
  );
endinterface

// File: rtl/uart_mmio_bridge.sv
// UART command-frame parser issuing single 32-bit MMIO reads/writes and replying ACK/NAK
// (plus little-endian read data) on the TX byte stream.
module uart_mmio_bridge #(
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               rst,
  uart_mmio_bridge_if.master link
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic        nak_q, nak_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] addr_sr_q, addr_sr_d;
  logic [31:0] data_sr_q, data_sr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] lat_q, lat_d;
  logic [31:0] idle_q, idle_d;

  logic       rx_ready, tx_valid, bus_we, bus_re;
  logic [7:0] tx_byte;
  logic [2:0] last_idx;

  assign last_idx = (nak_q || is_write_q) ? 3'd0 : 3'd4;

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    nak_d       = nak_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    lat_d       = lat_q;
    idle_d      = idle_q;
    rx_ready    = 1'b0;
    tx_valid    = 1'b0;
    bus_we      = 1'b0;
    bus_re      = 1'b0;

    unique case (state_q)
      StIdle: begin
        rx_ready = 1'b1;
        if (link.rx_valid) begin
          cnt_d     = 2'd0;
          idx_d     = 3'd0;
          idle_d    = 32'd0;
          data_sr_d = 32'd0;
          if (link.rx_data == 8'h52 || link.rx_data == 8'h57) begin
            is_write_d = (link.rx_data == 8'h57);
            nak_d      = 1'b0;
            state_d    = StAddr;
          end else begin
            is_write_d = 1'b0;
            nak_d      = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StAddr, StData: begin
        rx_ready = 1'b1;
        if (link.rx_valid) begin
          idle_d = 32'd0;
          cnt_d  = cnt_q + 2'd1;
          // Shift from the top so the first (least significant) byte ends up in [7:0].
          if (state_q == StAddr) addr_sr_d = {link.rx_data, addr_sr_q[31:8]};
          else                   data_sr_d = {link.rx_data, data_sr_q[31:8]};
          if (cnt_q == 2'd3) state_d = (state_q == StAddr && is_write_q) ? StData : StIssue;
        end else begin
          idle_d = idle_q + 32'd1;
          if (TIMEOUT_CYCLES != 32'd0 && idle_d == TIMEOUT_CYCLES) begin
            nak_d   = 1'b1;
            idx_d   = 3'd0;
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        bus_we  = is_write_q;
        bus_re  = ~is_write_q;
        lat_d   = 32'd0;
        idx_d   = 3'd0;
        state_d = is_write_q ? StResp : StWait;
      end
      StWait: begin
        lat_d = lat_q + 32'd1;
        if (lat_q == RD_LATENCY - 32'd1) begin
          rdata_d = link.bus_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        tx_valid = 1'b1;
        if (link.tx_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == last_idx) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The bus only ever sees a fully assembled address/data pair.
    if (state_d == StIssue && state_q != StIssue) begin
      bus_addr_d  = addr_sr_d;
      bus_wdata_d = data_sr_d;
    end
  end

  always_comb begin
    tx_byte = 8'h06;
    if (nak_q) begin
      tx_byte = 8'h15;
    end else begin
      case (idx_q)
        3'd1:    tx_byte = rdata_q[7:0];
        3'd2:    tx_byte = rdata_q[15:8];
        3'd3:    tx_byte = rdata_q[23:16];
        3'd4:    tx_byte = rdata_q[31:24];
        default: tx_byte = 8'h06;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      nak_q       <= 1'b0;
      cnt_q       <= 2'd0;
      idx_q       <= 3'd0;
      addr_sr_q   <= 32'd0;
      data_sr_q   <= 32'd0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      lat_q       <= 32'd0;
      idle_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      nak_q       <= nak_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      lat_q       <= lat_d;
      idle_q      <= idle_d;
    end
  end

  assign link.rx_ready  = rx_ready;
  assign link.tx_valid  = tx_valid;
  assign link.tx_data   = tx_valid ? tx_byte : 8'h00;
  assign link.bus_addr  = bus_addr_q;
  assign link.bus_wdata = bus_wdata_q;
  assign link.bus_we    = bus_we;
  assign link.bus_re    = bus_re;
  assign link.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: write, read, NAK, timeout, TX backpressure, reset.
module tb_uart_mmio_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_mmio_bridge_if bif();

  uart_mmio_bridge #(
    .RD_LATENCY    (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(bif)
  );

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          we_cnt, re_cnt, both_cnt;
  int          we_cyc, re_cyc, txv_cyc, acc_cyc;
  logic [31:0] we_addr, we_data, re_addr;
  logic        txv_prev = 1'b0;
  logic        re_prev = 1'b0;
  logic [31:0] rd_value = 32'h0;
  logic [7:0]  tx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: data valid only in the cycle after bus_re, junk otherwise.
  always @(negedge clk) begin
    bif.bus_rdata <= re_prev ? rd_value : 32'hDEADBEEF;
    re_prev       <= bif.bus_re;
  end

  always @(negedge clk) begin
    if (bif.bus_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= bif.bus_addr;
      we_data <= bif.bus_wdata;
      we_cyc  <= cyc;
    end
    if (bif.bus_re) begin
      re_cnt  <= re_cnt + 1;
      re_addr <= bif.bus_addr;
      re_cyc  <= cyc;
    end
    if (bif.bus_we && bif.bus_re) both_cnt <= both_cnt + 1;
    if (bif.tx_valid && !txv_prev) txv_cyc <= cyc;
    txv_prev <= bif.tx_valid;
    if (bif.tx_valid && bif.tx_ready) tx_q.push_back(bif.tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    we_cnt = 0; re_cnt = 0; both_cnt = 0;
    we_cyc = -1; re_cyc = -1; txv_cyc = -1;
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    while (!bif.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rx_accept_wait", 32'(n), 32'd0);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bif.rx_valid = 1'b0;
  endtask

  // Bytes go out lowest first.
  task automatic send_bytes(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8]);
  endtask

  task automatic wait_tx(input string tag, input int n);
    int k = 0;
    while (tx_q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check(tag, 32'(tx_q.size()), 32'(n));
  endtask

  int unstable;

  initial begin
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    bif.tx_ready = 1'b1;
    clear_log();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_tx_valid", 32'(bif.tx_valid), 32'd0);
    check("rst_strobes", {30'd0, bif.bus_we, bif.bus_re}, 32'd0);
    check("rst_addr", bif.bus_addr, 32'd0);
    check("rst_wdata", bif.bus_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: write
    clear_log();
    send_bytes(72'hDD_CC_BB_AA_80_00_00_18_57, 9);
    wait_tx("t1_tx_cnt", 1);
    check("t1_we_cnt", 32'(we_cnt), 32'd1);
    check("t1_re_cnt", 32'(re_cnt), 32'd0);
    check("t1_addr", we_addr, 32'h8000_0018);
    check("t1_wdata", we_data, 32'hDDCC_BBAA);
    check("t1_we_lat", 32'(we_cyc), 32'(acc_cyc + 1));
    check("t1_tx_lat", 32'(txv_cyc), 32'(acc_cyc + 2));
    check("t1_tx0", 32'(tx_q[0]), 32'h06);

    // 2: read
    clear_log();
    rd_value = 32'h1234_5678;
    send_bytes(72'h80_00_00_10_52, 5);
    wait_tx("t2_tx_cnt", 5);
    check("t2_re_cnt", 32'(re_cnt), 32'd1);
    check("t2_we_cnt", 32'(we_cnt), 32'd0);
    check("t2_addr", re_addr, 32'h8000_0010);
    check("t2_re_lat", 32'(re_cyc), 32'(acc_cyc + 1));
    check("t2_tx_lat", 32'(txv_cyc), 32'(acc_cyc + 3));
    check("t2_tx0", 32'(tx_q[0]), 32'h06);
    check("t2_tx1", 32'(tx_q[1]), 32'h78);
    check("t2_tx2", 32'(tx_q[2]), 32'h56);
    check("t2_tx3", 32'(tx_q[3]), 32'h34);
    check("t2_tx4", 32'(tx_q[4]), 32'h12);

    // 3: bad opcode, then a good read
    clear_log();
    send_byte(8'h41);
    wait_tx("t3_nak_cnt", 1);
    check("t3_nak", 32'(tx_q[0]), 32'h15);
    check("t3_no_strobe", 32'(we_cnt + re_cnt), 32'd0);
    clear_log();
    rd_value = 32'hA5A5_5A5A;
    send_bytes(72'h00_00_00_04_52, 5);
    wait_tx("t3_rd_cnt", 5);
    check("t3_rd_addr", re_addr, 32'h0000_0004);
    check("t3_rd_b1", 32'(tx_q[1]), 32'h5A);
    check("t3_rd_b4", 32'(tx_q[4]), 32'hA5);

    // 4: timeout mid-address, later byte starts a new frame
    clear_log();
    send_bytes(72'h00_10_52, 3);
    repeat (30) @(negedge clk);
    check("t4_nak_cnt", 32'(tx_q.size()), 32'd1);
    check("t4_nak", 32'(tx_q[0]), 32'h15);
    check("t4_no_strobe", 32'(we_cnt + re_cnt), 32'd0);
    check("t4_idle", 32'(bif.busy), 32'd0);
    clear_log();
    send_bytes(72'h44_33_22_11_00_00_00_04_57, 9);
    wait_tx("t4_wr_cnt", 1);
    check("t4_wr_we", 32'(we_cnt), 32'd1);
    check("t4_wr_data", we_data, 32'h4433_2211);
    check("t4_wr_ack", 32'(tx_q[0]), 32'h06);

    // 5: TX backpressure during read reply
    clear_log();
    @(posedge clk);
    #1;
    bif.tx_ready = 1'b0;
    rd_value = 32'hCAFE_F00D;
    send_bytes(72'h00_00_01_00_52, 5);
    begin
      int k = 0;
      while (!bif.tx_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bif.tx_valid || bif.tx_data !== 8'h06) unstable++;
    end
    check("t5_stable", 32'(unstable), 32'd0);
    @(posedge clk);
    #1;
    bif.tx_ready = 1'b1;
    wait_tx("t5_tx_cnt", 5);
    check("t5_tx0", 32'(tx_q[0]), 32'h06);
    check("t5_tx1", 32'(tx_q[1]), 32'h0D);
    check("t5_tx2", 32'(tx_q[2]), 32'hF0);
    check("t5_tx3", 32'(tx_q[3]), 32'hFE);
    check("t5_tx4", 32'(tx_q[4]), 32'hCA);

    // 6: reset mid-frame
    clear_log();
    send_bytes(72'h00_00_57, 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_busy", 32'(bif.busy), 32'd0);
    check("t6_tx_valid", 32'(bif.tx_valid), 32'd0);
    check("t6_addr", bif.bus_addr, 32'd0);
    check("t6_wdata", bif.bus_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_reply", 32'(tx_q.size()), 32'd0);
    send_bytes(72'h04_03_02_01_00_00_00_20_57, 9);
    wait_tx("t6_tx_cnt", 1);
    check("t6_we_cnt", 32'(we_cnt), 32'd1);
    check("t6_addr2", we_addr, 32'h0000_0020);
    check("t6_wdata2", we_data, 32'h0403_0201);
    check("t6_ack", 32'(tx_q[0]), 32'h06);

    check("both_strobes", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
